xpm_memory_tdpram: RTL and testbench
====================================

XPM_MEMORY_TDPRAM -- requirements
Module: xpm_memory_tdpram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH_A, default 10: port A address width.
REQ-002 SHALL have parameter ADDR_WIDTH_B, default 10: port B address width; must equal ADDR_WIDTH_A.
REQ-003 SHALL have parameter WRITE_DATA_WIDTH_A, default 32: port A word width; READ_DATA_WIDTH_A, WRITE/READ_DATA_WIDTH_B, default 32, must be equal to it.
REQ-004 SHALL have parameters BYTE_WRITE_WIDTH_A and BYTE_WRITE_WIDTH_B, default 32: write-enable granule, either 8 or the full word width.
REQ-005 SHALL have parameter MEMORY_SIZE, default 32768: total bits, equal to word width x 2^ADDR_WIDTH_A.
REQ-006 SHALL have parameters READ_LATENCY_A and READ_LATENCY_B, default 1; only 1 is supported.
REQ-007 SHALL have parameters WRITE_MODE_A and WRITE_MODE_B, default "write_first"; only "write_first" is supported.
REQ-008 SHALL accept and ignore CLOCKING_MODE, ECC_MODE, MEMORY_PRIMITIVE, MEMORY_INIT_FILE, MEMORY_INIT_PARAM, USE_MEM_INIT, AUTO_SLEEP_TIME, CASCADE_HEIGHT, IGNORE_INIT_SYNTH, MEMORY_OPTIMIZATION, MESSAGE_CONTROL, WRITE_PROTECT.
REQ-009 One clock; reset is asynchronous and active-low.
REQ-010 clk  input  1  rising-edge clock for both ports.
REQ-011 rst_n  input  1  asynchronous active-low reset of output registers.
REQ-012 ena / enb  input  1  port A / B enable.
REQ-013 addra / addrb  input  ADDR_WIDTH  word address.
REQ-014 dina / dinb  input  WDW  write data.
REQ-015 wea / web  input  WDW/BYTE_WRITE_WIDTH  per-granule write enable, bit i covers data bits [i*BWW +: BWW].
REQ-016 douta / doutb  output  WDW  registered read data.
REQ-017 regcea, regceb, sleep, injectsbiterra/b, injectdbiterra/b  input  1  accepted and ignored (regce meaningless at latency 1).

Function
REQ-018 Storage SHALL be 2^ADDR_WIDTH words, all zero at time zero (simulation init); contents never cleared by reset.
REQ-019 On rising clk with rst_n=1 and enX=1, for each granule i: if weX[i]=1, write dinX granule i to mem[addrX] and load it into doutX granule i; else load mem[addrX] granule i (pre-edge value) into doutX.
REQ-020 Read latency SHALL be exactly 1 cycle: data for address presented at edge N appears on doutX after edge N and holds until the next enabled edge.
REQ-021 enX=0: no write, doutX holds its previous value regardless of weX/addrX.
REQ-022 Write-first: a write returns the newly written granules on doutX the same edge; unwritten granules return old memory contents.
REQ-023 Cross-port same address, same edge: a reading port returns pre-edge contents (old data) for granules written by the other port.
REQ-024 Both ports write same granule of same address on the same edge: port B's data SHALL be stored; each port's dout still shows its own written data.
REQ-025 Ports SHALL be fully independent otherwise: any address combination, simultaneous read/read, read/write, write/write.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear douta and doutb to 0 and hold them at 0 while asserted; memory writes and reads are suppressed during reset.
REQ-027 Reset deassertion SHALL take effect at the next rising clk; no writes occur on the deasserting edge's prior cycles.
REQ-028 Reset mid-operation SHALL not corrupt memory contents already written.

Verification
REQ-029 Reset, no access -> douta=doutb=0; after release, read A addr 5 -> douta=0 next cycle.
REQ-030 BWW=32: B writes 0xDEADBEEF to addr 3 (web=1) -> doutb=0xDEADBEEF same edge; A reads addr 3 next cycle -> douta=0xDEADBEEF one cycle later.
REQ-031 BWW=8: addr 7 holds 0x11223344; A writes dina=0xAABBCCDD wea=4'b0101 -> douta=0x11BB33DD and mem[7]=0x11BB33DD.
REQ-032 Same edge: A writes 0x1 to addr 9 (old 0x0), B reads addr 9 -> doutb=0x0; next B read -> 0x1.
REQ-033 Same edge both write addr 2: A 0xA, B 0xB -> douta=0xA, doutb=0xB, subsequent read = 0xB.
REQ-034 ena=0 with wea=1 -> memory unchanged, douta holds; rst_n pulse low mid-run -> outputs 0 immediately, prior data still readable after release.

Source files
------------

// File: rtl/xpm_memory_tdpram_if.sv
// ---------------------------------------------------------------------------
// xpm_memory_tdpram_if
// Bus bundle for the true dual-port RAM. Both ports share one clock and one
// reset, which stay plain ports on the memory itself.
//   ena/enb         port enable
//   addra/addrb     word address
//   dina/dinb       write data
//   wea/web         per-granule write enable
//   douta/doutb     registered read data (driven by the memory)
//   regcea/regceb, sleep, injectsbiterr*/injectdbiterr*  accepted, unused
// master = user side, slave = memory side.
// ---------------------------------------------------------------------------
interface xpm_memory_tdpram_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int WEA_WIDTH  = 1,
  parameter int WEB_WIDTH  = 1
);
  logic                  ena;
  logic                  enb;
  logic [ADDR_WIDTH-1:0] addra;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] dinb;
  logic [WEA_WIDTH-1:0]  wea;
  logic [WEB_WIDTH-1:0]  web;
  logic [DATA_WIDTH-1:0] douta;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  regcea;
  logic                  regceb;
  logic                  sleep;
  logic                  injectsbiterra;
  logic                  injectdbiterra;
  logic                  injectsbiterrb;
  logic                  injectdbiterrb;

  modport master (
    output ena, enb, addra, addrb, dina, dinb, wea, web,
           regcea, regceb, sleep,
           injectsbiterra, injectdbiterra, injectsbiterrb, injectdbiterrb,
    input  douta, doutb
  );

  modport slave (
    input  ena, enb, addra, addrb, dina, dinb, wea, web,
           regcea, regceb, sleep,
           injectsbiterra, injectdbiterra, injectsbiterrb, injectdbiterrb,
    output douta, doutb
  );
endinterface

// File: rtl/xpm_memory_tdpram.sv
// ---------------------------------------------------------------------------
// xpm_memory_tdpram
// Common-clock true dual-port RAM, read latency 1, write-first on each port.
//   clk    rising-edge clock for both ports
//   rst_n  asynchronous active-low reset of douta/doutb only
//   bus    xpm_memory_tdpram_if.slave (enables, addresses, data, byte
//          enables, registered outputs, ignored side-band inputs)
// A port returns its own written granules and pre-edge memory contents for
// the rest, so a read on one port never sees the other port's same-edge
// write. When both ports write one granule on one edge, port B's data stays.
// ---------------------------------------------------------------------------
module xpm_memory_tdpram #(
  parameter int    ADDR_WIDTH_A        = 10,
  parameter int    ADDR_WIDTH_B        = 10,
  parameter int    WRITE_DATA_WIDTH_A  = 32,
  parameter int    READ_DATA_WIDTH_A   = 32,
  parameter int    WRITE_DATA_WIDTH_B  = 32,
  parameter int    READ_DATA_WIDTH_B   = 32,
  parameter int    BYTE_WRITE_WIDTH_A  = 32,
  parameter int    BYTE_WRITE_WIDTH_B  = 32,
  parameter int    MEMORY_SIZE         = 32768,
  parameter int    READ_LATENCY_A      = 1,
  parameter int    READ_LATENCY_B      = 1,
  parameter string WRITE_MODE_A        = "write_first",
  parameter string WRITE_MODE_B        = "write_first",
  parameter string CLOCKING_MODE       = "common_clock",
  parameter string ECC_MODE            = "no_ecc",
  parameter string MEMORY_PRIMITIVE    = "auto",
  parameter string MEMORY_INIT_FILE    = "none",
  parameter string MEMORY_INIT_PARAM   = "0",
  parameter int    USE_MEM_INIT        = 1,
  parameter int    AUTO_SLEEP_TIME     = 0,
  parameter int    CASCADE_HEIGHT      = 0,
  parameter int    IGNORE_INIT_SYNTH   = 0,
  parameter string MEMORY_OPTIMIZATION = "true",
  parameter int    MESSAGE_CONTROL     = 0,
  parameter int    WRITE_PROTECT       = 1
) (
  input logic                clk,
  input logic                rst_n,
  xpm_memory_tdpram_if.slave bus
);

  localparam int DW    = WRITE_DATA_WIDTH_A;
  localparam int DEPTH = 2 ** ADDR_WIDTH_A;
  localparam int BWA   = BYTE_WRITE_WIDTH_A;
  localparam int BWB   = BYTE_WRITE_WIDTH_B;
  localparam int NWE_A = DW / BWA;
  localparam int NWE_B = DW / BWB;

  // Only the symmetric, latency-1, write-first configuration is built.
  if (ADDR_WIDTH_B != ADDR_WIDTH_A || READ_DATA_WIDTH_A != DW ||
      WRITE_DATA_WIDTH_B != DW || READ_DATA_WIDTH_B != DW ||
      MEMORY_SIZE != DW * DEPTH || READ_LATENCY_A != 1 ||
      READ_LATENCY_B != 1 || (BWA != 8 && BWA != DW) ||
      (BWB != 8 && BWB != DW) || WRITE_MODE_A != "write_first" ||
      WRITE_MODE_B != "write_first") begin : g_bad_cfg
    $error("xpm_memory_tdpram: unsupported parameter combination");
  end

  // NOTE: the storage array is deliberately outside the reset branch below;
  // a reset only clears the output registers, so earlier writes survive it.
  // The declaration initialiser gives the all-zero power-up contents.
  logic [DW-1:0] mem_q [DEPTH] = '{default: '0};

  logic [DW-1:0] douta_q, douta_d;
  logic [DW-1:0] doutb_q, doutb_d;

  // Write-first merge: own written granules, pre-edge contents elsewhere.
  always_comb begin
    douta_d = mem_q[bus.addra];
    for (int i = 0; i < NWE_A; i++) begin
      if (bus.wea[i]) douta_d[i*BWA +: BWA] = bus.dina[i*BWA +: BWA];
    end
  end

  always_comb begin
    doutb_d = mem_q[bus.addrb];
    for (int i = 0; i < NWE_B; i++) begin
      if (bus.web[i]) doutb_d[i*BWB +: BWB] = bus.dinb[i*BWB +: BWB];
    end
  end

  // NOTE: non-blocking writes keep every read on this edge seeing pre-edge
  // contents; port B's writes come after port A's so B wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta_q <= '0;
      doutb_q <= '0;
    end else begin
      if (bus.ena) begin
        douta_q <= douta_d;
        for (int i = 0; i < NWE_A; i++) begin
          if (bus.wea[i]) mem_q[bus.addra][i*BWA +: BWA] <= bus.dina[i*BWA +: BWA];
        end
      end
      if (bus.enb) begin
        doutb_q <= doutb_d;
        for (int i = 0; i < NWE_B; i++) begin
          if (bus.web[i]) mem_q[bus.addrb][i*BWB +: BWB] <= bus.dinb[i*BWB +: BWB];
        end
      end
    end
  end

  assign bus.douta = douta_q;
  assign bus.doutb = doutb_q;

  // Side-band inputs have no function at latency 1 without ECC.
  logic unused_sideband;
  assign unused_sideband = ^{bus.regcea, bus.regceb, bus.sleep,
                             bus.injectsbiterra, bus.injectdbiterra,
                             bus.injectsbiterrb, bus.injectdbiterrb};

endmodule

// File: tb/tb_xpm_memory_tdpram.sv
// ---------------------------------------------------------------------------
// tb_xpm_memory_tdpram
// Drives a 16 x 32-bit, byte-writable instance of xpm_memory_tdpram with
// directed and random traffic and compares both outputs every clock with an
// array-based model of the RAM. Literal expectations pin the model on the
// documented scenarios.
// ---------------------------------------------------------------------------
module tb_xpm_memory_tdpram;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int NWE   = DW / BW;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  xpm_memory_tdpram_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WEA_WIDTH(NWE), .WEB_WIDTH(NWE)
  ) bus ();

  xpm_memory_tdpram #(
    .ADDR_WIDTH_A(AW), .ADDR_WIDTH_B(AW),
    .WRITE_DATA_WIDTH_A(DW), .READ_DATA_WIDTH_A(DW),
    .WRITE_DATA_WIDTH_B(DW), .READ_DATA_WIDTH_B(DW),
    .BYTE_WRITE_WIDTH_A(BW), .BYTE_WRITE_WIDTH_B(BW),
    .MEMORY_SIZE(DW * DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: word array plus expected output registers.
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_a = '0;
  logic [DW-1:0] exp_b = '0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [NWE-1:0] we);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NWE; i++)
      if (we[i]) r[i*BW +: BW] = new_w[i*BW +: BW];
    return r;
  endfunction

  // One clock edge of the documented behaviour.
  task automatic model_edge();
    logic [DW-1:0] old_a, old_b;
    if (!rst_n) begin
      exp_a = '0;
      exp_b = '0;
    end else begin
      old_a = model_mem[bus.addra];
      old_b = model_mem[bus.addrb];
      if (bus.ena) exp_a = merge(old_a, bus.dina, bus.wea);
      if (bus.enb) exp_b = merge(old_b, bus.dinb, bus.web);
      if (bus.ena) model_mem[bus.addra] = merge(model_mem[bus.addra], bus.dina, bus.wea);
      if (bus.enb) model_mem[bus.addrb] = merge(model_mem[bus.addrb], bus.dinb, bus.web);
    end
  endtask

  // Advance one edge, then compare both outputs 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("douta", bus.douta, exp_a);
    check("doutb", bus.doutb, exp_b);
  endtask

  task automatic port_a(input logic en, input logic [NWE-1:0] we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] din);
    bus.ena = en; bus.wea = we; bus.addra = addr; bus.dina = din;
  endtask

  task automatic port_b(input logic en, input logic [NWE-1:0] we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] din);
    bus.enb = en; bus.web = we; bus.addrb = addr; bus.dinb = din;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    rst_n = 1'b1;
    port_a(1'b0, '0, '0, '0);
    port_b(1'b0, '0, '0, '0);
    bus.regcea = 1'b1; bus.regceb = 1'b1; bus.sleep = 1'b0;
    bus.injectsbiterra = 1'b0; bus.injectdbiterra = 1'b0;
    bus.injectsbiterrb = 1'b0; bus.injectdbiterrb = 1'b0;

    // Reset state; writes attempted during reset must be dropped.
    #1 rst_n = 1'b0;
    #1;
    check("rst_douta", bus.douta, 32'h0);
    check("rst_doutb", bus.doutb, 32'h0);
    port_a(1'b1, 4'hF, 4'd0, 32'h5555_5555);
    port_b(1'b1, 4'hF, 4'd1, 32'h6666_6666);
    cycle();
    cycle();
    rst_n = 1'b1;

    // Read of never-written address 5.
    port_a(1'b1, 4'h0, 4'd5, 32'h0);
    port_b(1'b0, 4'h0, 4'd0, 32'h0);
    cycle();
    check("rd5_douta", bus.douta, 32'h0);

    // Full-word B write, then A reads it back.
    port_a(1'b0, 4'h0, 4'd0, 32'h0);
    port_b(1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF);
    cycle();
    check("wr3_doutb", bus.doutb, 32'hDEAD_BEEF);
    port_b(1'b0, 4'h0, 4'd0, 32'h0);
    port_a(1'b1, 4'h0, 4'd3, 32'h0);
    cycle();
    check("rd3_douta", bus.douta, 32'hDEAD_BEEF);

    // Byte-granular write over existing data.
    port_a(1'b1, 4'hF, 4'd7, 32'h1122_3344);
    cycle();
    port_a(1'b1, 4'b0101, 4'd7, 32'hAABB_CCDD);
    cycle();
    check("bw7_douta", bus.douta, 32'h11BB_33DD);
    port_a(1'b0, 4'h0, 4'd0, 32'h0);
    port_b(1'b1, 4'h0, 4'd7, 32'h0);
    cycle();
    check("bw7_mem", bus.doutb, 32'h11BB_33DD);

    // A writes while B reads the same address: B sees old data.
    port_a(1'b1, 4'hF, 4'd9, 32'h1);
    port_b(1'b1, 4'h0, 4'd9, 32'h0);
    cycle();
    check("xrd_old", bus.doutb, 32'h0);
    port_a(1'b0, 4'h0, 4'd0, 32'h0);
    cycle();
    check("xrd_new", bus.doutb, 32'h1);

    // Both ports write address 2: B's data is stored.
    port_a(1'b1, 4'hF, 4'd2, 32'hA);
    port_b(1'b1, 4'hF, 4'd2, 32'hB);
    cycle();
    check("ww_douta", bus.douta, 32'hA);
    check("ww_doutb", bus.doutb, 32'hB);
    port_a(1'b1, 4'h0, 4'd2, 32'h0);
    port_b(1'b0, 4'h0, 4'd0, 32'h0);
    cycle();
    check("ww_stored", bus.douta, 32'hB);

    // Disabled port: write ignored, output held.
    port_a(1'b0, 4'hF, 4'd2, 32'hFFFF_FFFF);
    cycle();
    check("dis_hold", bus.douta, 32'hB);
    port_a(1'b1, 4'h0, 4'd2, 32'h0);
    cycle();
    check("dis_nowr", bus.douta, 32'hB);

    // Asynchronous reset mid-run; contents must survive.
    #2 rst_n = 1'b0;
    #1;
    exp_a = '0;
    exp_b = '0;
    check("arst_douta", bus.douta, 32'h0);
    check("arst_doutb", bus.doutb, 32'h0);
    port_a(1'b1, 4'hF, 4'd3, 32'h0BAD_0BAD);
    port_b(1'b1, 4'hF, 4'd7, 32'h0BAD_0BAD);
    cycle();
    rst_n = 1'b1;
    port_a(1'b1, 4'h0, 4'd3, 32'h0);
    port_b(1'b1, 4'h0, 4'd7, 32'h0);
    cycle();
    check("keep3", bus.douta, 32'hDEAD_BEEF);
    check("keep7", bus.doutb, 32'h11BB_33DD);

    // Random traffic with occasional reset cycles.
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      port_a($urandom_range(0, 3) != 0, NWE'($urandom), AW'($urandom), $urandom);
      port_b($urandom_range(0, 3) != 0, NWE'($urandom), AW'($urandom), $urandom);
      cycle();
    end

    // Sweep every address on both ports.
    rst_n = 1'b1;
    for (int n = 0; n < DEPTH; n++) begin
      port_a(1'b1, 4'h0, AW'(n), 32'h0);
      port_b(1'b1, 4'h0, AW'(DEPTH - 1 - n), 32'h0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
